// File: rtl/jk_mod_counter.sv
// Loadable up/down modulo-N counter whose state bits are JK stages.
// The block derives per-bit J/K excitation each cycle and applies Q+ = J&~Q | ~K&Q.
module jk_mod_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             Clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] Q,
  output logic             tc,
  output logic             load_err,
  output logic [WIDTH-1:0] J,
  output logic [WIDTH-1:0] K
);

  generate
    if (MODULUS < 2 || MODULUS > (2 ** WIDTH)) begin : g_bad_modulus
      $error("jk_mod_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
    end
  endgenerate

  // Comparing against the last legal value keeps every compare WIDTH bits,
  // even when MODULUS == 2**WIDTH is not itself representable.
  localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

  logic             d_ok;
  logic             at_last;
  logic             at_zero;
  logic             q_oor;
  logic [WIDTH-1:0] count_next;
  logic             err_next;

  always_comb begin
    d_ok    = (d <= LAST);
    at_last = (Q == LAST);
    at_zero = (Q == '0);
    q_oor   = (Q > LAST);

    if (q_oor) begin
      count_next = '0;
    end else if (up) begin
      count_next = at_last ? '0 : Q + WIDTH'(1);
    end else begin
      count_next = at_zero ? LAST : Q - WIDTH'(1);
    end

    tc = en & ~load & ~rst & ((up & at_last) | (~up & at_zero));
  end

  // Loads and resets use set/clear excitation; counting uses toggle excitation
  // so that only the bits that actually change see J=K=1.
  always_comb begin
    J        = '0;
    K        = '0;
    err_next = load_err;
    if (rst) begin
      J        = '0;
      K        = '1;
      err_next = 1'b0;
    end else if (load) begin
      if (d_ok) begin
        J        = d;
        K        = ~d;
        err_next = 1'b0;
      end else begin
        J        = '0;
        K        = '1;
        err_next = 1'b1;
      end
    end else if (en) begin
      J = Q ^ count_next;
      K = Q ^ count_next;
    end
  end

  // JK storage: reset reaches Q through the clear excitation above.
  always_ff @(posedge Clk) begin
    Q <= (J & ~Q) | (~K & Q);
    if (rst) begin
      load_err <= 1'b0;
    end else begin
      load_err <= err_next;
    end
  end

endmodule

// File: tb/tb_jk_mod_counter.sv
// Scoreboard bench for jk_mod_counter: directed vectors push expectations,
// a monitor pops one entry per cycle and checks J/K/tc before the edge and Q after.
module tb_jk_mod_counter;

  logic       Clk;
  logic       rst, en, up, load;
  logic [3:0] d;
  logic [3:0] Q, J, K;
  logic       tc, load_err;

  logic       rst_c, en_c;
  logic [3:0] units_q, units_j, units_k, tens_q, tens_j, tens_k;
  logic       units_tc, units_err, tens_tc, tens_err;

  jk_mod_counter #(.WIDTH(4), .MODULUS(10)) dut (
    .Clk(Clk), .rst(rst), .en(en), .up(up), .load(load), .d(d),
    .Q(Q), .tc(tc), .load_err(load_err), .J(J), .K(K)
  );

  jk_mod_counter #(.WIDTH(4), .MODULUS(10)) u_units (
    .Clk(Clk), .rst(rst_c), .en(en_c), .up(1'b1), .load(1'b0), .d(4'd0),
    .Q(units_q), .tc(units_tc), .load_err(units_err), .J(units_j), .K(units_k)
  );

  jk_mod_counter #(.WIDTH(4), .MODULUS(10)) u_tens (
    .Clk(Clk), .rst(rst_c), .en(units_tc), .up(1'b1), .load(1'b0), .d(4'd0),
    .Q(tens_q), .tc(tens_tc), .load_err(tens_err), .J(tens_j), .K(tens_k)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    int         id;
    logic [3:0] ej;
    logic [3:0] ek;
    logic       etc;
    logic [3:0] eq;
    logic       eerr;
    logic       cas_chk;
    logic [3:0] eu;
    logic [3:0] et;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   step_id = 0;

  logic       cas_rst = 1'b1;
  logic       cas_en  = 1'b0;
  logic       cas_chk = 1'b0;
  logic [3:0] cas_u   = 4'd0;
  logic [3:0] cas_t   = 4'd0;

  task automatic check(input string nm, input int id, input logic [31:0] got,
                       input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s step %0d got %0h expected %0h", nm, id, got, expv);
    end
  endtask

  task automatic apply(input logic r, input logic l, input logic e, input logic u,
                       input logic [3:0] dv, input logic [3:0] ej, input logic [3:0] ek,
                       input logic etc, input logic [3:0] eq, input logic eerr);
    exp_t x;
    @(negedge Clk);
    #1;
    rst   = r;
    load  = l;
    en    = e;
    up    = u;
    d     = dv;
    rst_c = cas_rst;
    en_c  = cas_en;
    x.id = step_id;
    x.ej = ej;
    x.ek = ek;
    x.etc = etc;
    x.eq = eq;
    x.eerr = eerr;
    x.cas_chk = cas_chk;
    x.eu = cas_u;
    x.et = cas_t;
    sb.push_back(x);
    step_id++;
  endtask

  exp_t       m;
  logic [3:0] pj, pk, pq;

  initial begin
    forever begin
      @(negedge Clk);
      #3;
      if (sb.size() != 0) begin
        m = sb.pop_front();
        check("J", m.id, {28'd0, J}, {28'd0, m.ej});
        check("K", m.id, {28'd0, K}, {28'd0, m.ek});
        check("tc", m.id, {31'd0, tc}, {31'd0, m.etc});
        pj = J;
        pk = K;
        pq = Q;
        @(posedge Clk);
        #1;
        check("Q", m.id, {28'd0, Q}, {28'd0, m.eq});
        check("load_err", m.id, {31'd0, load_err}, {31'd0, m.eerr});
        check("jk_inv", m.id, {28'd0, Q}, {28'd0, (pj & ~pq) | (~pk & pq)});
        if (m.cas_chk) begin
          check("units", m.id, {28'd0, units_q}, {28'd0, m.eu});
          check("tens", m.id, {28'd0, tens_q}, {28'd0, m.et});
        end
      end
    end
  end

  initial begin
    logic [3:0] pre, post;
    rst = 1'b1; load = 1'b0; en = 1'b0; up = 1'b1; d = 4'd0;
    rst_c = 1'b1; en_c = 1'b0;

    // reset
    apply(1, 0, 0, 1, 4'd0, 4'h0, 4'hF, 0, 4'd0, 0);
    apply(1, 0, 0, 1, 4'd0, 4'h0, 4'hF, 0, 4'd0, 0);

    // up count 0..9,0,1
    for (int i = 0; i < 12; i++) begin
      pre  = 4'(i % 10);
      post = 4'((i + 1) % 10);
      apply(0, 0, 1, 1, 4'd0, pre ^ post, pre ^ post, (pre == 4'd9), post, 0);
    end

    // load 0 then down count through the wrap
    apply(0, 1, 0, 1, 4'd0, 4'h0, 4'hF, 0, 4'd0, 0);
    apply(0, 0, 1, 0, 4'd0, 4'h9, 4'h9, 1, 4'd9, 0);
    apply(0, 0, 1, 0, 4'd0, 4'h1, 4'h1, 0, 4'd8, 0);
    apply(0, 0, 1, 0, 4'd0, 4'hF, 4'hF, 0, 4'd7, 0);

    // load beats en; out-of-range load; error held
    apply(0, 1, 1, 0, 4'd6, 4'h6, 4'h9, 0, 4'd6, 0);
    apply(0, 1, 1, 0, 4'd12, 4'h0, 4'hF, 0, 4'd0, 1);
    for (int i = 0; i < 3; i++) apply(0, 0, 0, 0, 4'd0, 4'h0, 4'h0, 0, 4'd0, 1);

    // hold at 5, then hold at 9 with up=1
    apply(0, 1, 0, 1, 4'd5, 4'h5, 4'hA, 0, 4'd5, 0);
    for (int i = 0; i < 4; i++) apply(0, 0, 0, 1, 4'd0, 4'h0, 4'h0, 0, 4'd5, 0);
    apply(0, 1, 0, 1, 4'd9, 4'h9, 4'h6, 0, 4'd9, 0);
    apply(0, 0, 0, 1, 4'd0, 4'h0, 4'h0, 0, 4'd9, 0);

    // load masks tc at Q=9; rst beats load at Q=8; counting resumes
    apply(0, 1, 1, 1, 4'd8, 4'h8, 4'h7, 0, 4'd8, 0);
    apply(1, 1, 1, 1, 4'd3, 4'h0, 4'hF, 0, 4'd0, 0);
    apply(0, 0, 1, 1, 4'd0, 4'h1, 4'h1, 0, 4'd1, 0);

    // d == MODULUS boundary; err survives counting; rst clears it
    apply(0, 1, 0, 1, 4'd10, 4'h0, 4'hF, 0, 4'd0, 1);
    apply(0, 0, 1, 1, 4'd0, 4'h1, 4'h1, 0, 4'd1, 1);
    apply(1, 0, 1, 1, 4'd0, 4'h0, 4'hF, 0, 4'd0, 0);

    // largest legal load, then wraps in both directions
    apply(0, 1, 0, 1, 4'd9, 4'h9, 4'h6, 0, 4'd9, 0);
    apply(0, 0, 1, 1, 4'd0, 4'h9, 4'h9, 1, 4'd0, 0);
    apply(0, 0, 1, 0, 4'd0, 4'h9, 4'h9, 1, 4'd9, 0);
    apply(0, 0, 1, 1, 4'd0, 4'h9, 4'h9, 1, 4'd0, 0);

    // cascade: 25 enabled cycles from reset, main counter holds
    cas_rst = 1'b0;
    cas_en  = 1'b1;
    cas_chk = 1'b1;
    for (int i = 1; i <= 25; i++) begin
      cas_u = 4'(i % 10);
      cas_t = 4'(i / 10);
      apply(0, 0, 0, 1, 4'd0, 4'h0, 4'h0, 0, 4'd0, 0);
    end

    @(negedge Clk);
    en_c = 1'b0;
    for (int n = 0; n < 20 && sb.size() != 0; n++) @(posedge Clk);
    repeat (2) @(posedge Clk);
    #2;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain pending %0d expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
